// File: rtl/sp_eval_fetch_pkg.sv
// Shared sprite-pipeline types: secondary OAM entry, back-buffer entry and
// the evaluation state encoding.
package sp_eval_fetch_pkg;

    localparam int SPRITE_WIDTH  = 8;
    localparam int SPRITE_H      = 8;
    localparam int N_SPRITES     = 64;
    localparam int SEC_OAM_SLOTS = 8;

    typedef struct packed {
        logic                    active;
        logic [7:0]              x_pos;
        logic [7:0]              attribute;
        logic [SPRITE_WIDTH-1:0] bitmap_lo;
        logic [SPRITE_WIDTH-1:0] bitmap_hi;
    } second_oam_t;

    // Back-buffer slot keeps what the pattern fetch needs beyond the front view.
    typedef struct packed {
        second_oam_t sp;
        logic [7:0]  tile;
        logic [2:0]  row_diff;
    } back_entry_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_EVAL_Y,
        S_EVAL_T,
        S_EVAL_A,
        S_EVAL_X,
        S_FETCH_LO,
        S_FETCH_HI
    } eval_state_t;

endpackage

// File: rtl/sp_eval_fetch_pat_addr.sv
// Pattern-table byte address for one sprite row/plane, with vertical flip.
module sp_pat_addr (
    input  logic [7:0]  tile,
    input  logic [2:0]  row_diff,
    input  logic        vflip,
    input  logic        table_sel,
    input  logic        plane,
    output logic [13:0] addr
);
    logic [2:0] fine_y;

    always_comb begin
        fine_y = vflip ? (3'd7 - row_diff) : row_diff;
        addr   = {1'b0, table_sel, tile, plane, fine_y};
    end
endmodule

// File: rtl/sp_eval_fetch.sv
// Per-scanline sprite evaluation and pattern fetch into a double-buffered
// eight-slot secondary OAM.
//   state      | meaning
//   S_IDLE     | waiting for eval_start; swap copies back to front
//   S_CLEAR    | wipe back buffer, slot count and flags
//   S_EVAL_Y   | read Y of sprite spr, range test (2 cycles)
//   S_EVAL_T/A/X | read tile / attribute / X into the next slot (2 cycles each)
//   S_FETCH_LO | low plane read for slot fidx (skip if inactive)
//   S_FETCH_HI | high plane read for slot fidx
module sp_eval_fetch
    import sp_eval_fetch_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   eval_start,
    input  logic [8:0]             target_row,
    input  logic                   swap,
    input  logic                   sp_table_sel,
    output logic [7:0]             oam_addr,
    input  logic [7:0]             oam_rdata,
    output logic                   vram_req,
    output logic [13:0]            vram_addr,
    input  logic                   vram_ack,
    input  logic [7:0]             vram_rdata,
    output second_oam_t [7:0]      sec_oam,
    output logic                   sp0_present,
    output logic                   sp_overflow,
    output logic                   busy
);
    eval_state_t        state, state_nx;
    logic               phase;
    logic [5:0]         spr;
    logic [3:0]         slot_cnt;
    logic [2:0]         slot_idx;
    logic [2:0]         fidx;
    logic [8:0]         row_q;
    back_entry_t [7:0]  back;
    logic               back_sp0, back_ovf;
    logic               gap;
    logic [8:0]         diff;
    logic               in_range, last_spr, last_slot, cur_active, plane, xfer;
    logic [13:0]        pat_addr;

    assign diff       = row_q - {1'b0, oam_rdata};
    assign in_range   = diff < 9'(SPRITE_H);
    assign last_spr   = spr == 6'(N_SPRITES - 1);
    assign last_slot  = fidx == 3'(SEC_OAM_SLOTS - 1);
    assign slot_idx   = slot_cnt[2:0];
    assign cur_active = back[fidx].sp.active;
    assign plane      = state == S_FETCH_HI;
    assign xfer       = vram_req && vram_ack;

    sp_pat_addr u_pat_addr (
        .tile      (back[fidx].tile),
        .row_diff  (back[fidx].row_diff),
        .vflip     (back[fidx].sp.attribute[7]),
        .table_sel (sp_table_sel),
        .plane     (plane),
        .addr      (pat_addr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (eval_start) begin
            state_nx = S_CLEAR;
        end else begin
            case (state)
                S_IDLE:   state_nx = S_IDLE;
                S_CLEAR:  state_nx = S_EVAL_Y;
                S_EVAL_Y: if (phase) begin
                    if (in_range)
                        state_nx = (slot_cnt == 4'(SEC_OAM_SLOTS)) ? S_FETCH_LO : S_EVAL_T;
                    else if (last_spr)
                        state_nx = S_FETCH_LO;
                end
                S_EVAL_T: if (phase) state_nx = S_EVAL_A;
                S_EVAL_A: if (phase) state_nx = S_EVAL_X;
                S_EVAL_X: if (phase) state_nx = last_spr ? S_FETCH_LO : S_EVAL_Y;
                S_FETCH_LO: begin
                    if (!cur_active) state_nx = last_slot ? S_IDLE : S_FETCH_LO;
                    else if (xfer)   state_nx = S_FETCH_HI;
                end
                S_FETCH_HI: if (xfer) state_nx = last_slot ? S_IDLE : S_FETCH_LO;
                default:  state_nx = S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy      = state != S_IDLE;
        oam_addr  = '0;
        vram_req  = 1'b0;
        case (state)
            S_EVAL_Y:   oam_addr = {spr, 2'd0};
            S_EVAL_T:   oam_addr = {spr, 2'd1};
            S_EVAL_A:   oam_addr = {spr, 2'd2};
            S_EVAL_X:   oam_addr = {spr, 2'd3};
            // One idle cycle after every ack so each read is a separate request.
            S_FETCH_LO,
            S_FETCH_HI: vram_req = cur_active && !gap;
            default:    ;
        endcase
        vram_addr = vram_req ? pat_addr : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sec_oam     <= '0;
            sp0_present <= 1'b0;
            sp_overflow <= 1'b0;
            back        <= '0;
            back_sp0    <= 1'b0;
            back_ovf    <= 1'b0;
            row_q       <= '0;
            phase       <= 1'b0;
            spr         <= '0;
            slot_cnt    <= '0;
            fidx        <= '0;
            gap         <= 1'b0;
        end else begin
            if (swap) begin
                if (state == S_IDLE) begin
                    for (int i = 0; i < SEC_OAM_SLOTS; i++) sec_oam[i] <= back[i].sp;
                    sp0_present <= back_sp0;
                    sp_overflow <= back_ovf;
                end else begin
                    sec_oam     <= '0;
                    sp0_present <= 1'b0;
                    sp_overflow <= 1'b0;
                end
            end
            if (eval_start) row_q <= target_row;
            gap <= xfer;
            case (state)
                S_CLEAR: begin
                    back     <= '0;
                    back_sp0 <= 1'b0;
                    back_ovf <= 1'b0;
                    slot_cnt <= '0;
                    spr      <= '0;
                    phase    <= 1'b0;
                    fidx     <= '0;
                end
                S_EVAL_Y: begin
                    phase <= !phase;
                    if (phase) begin
                        if (!in_range) begin
                            spr <= spr + 6'd1;
                        end else if (slot_cnt == 4'(SEC_OAM_SLOTS)) begin
                            back_ovf <= 1'b1;
                        end else begin
                            back[slot_idx].row_diff <= diff[2:0];
                            if (spr == 6'd0) back_sp0 <= 1'b1;
                        end
                    end
                end
                S_EVAL_T: begin
                    phase <= !phase;
                    if (phase) back[slot_idx].tile <= oam_rdata;
                end
                S_EVAL_A: begin
                    phase <= !phase;
                    if (phase) back[slot_idx].sp.attribute <= oam_rdata;
                end
                S_EVAL_X: begin
                    phase <= !phase;
                    if (phase) begin
                        back[slot_idx].sp.x_pos  <= oam_rdata;
                        back[slot_idx].sp.active <= 1'b1;
                        slot_cnt <= slot_cnt + 4'd1;
                        spr      <= spr + 6'd1;
                    end
                end
                S_FETCH_LO: begin
                    if (!cur_active) fidx <= fidx + 3'd1;
                    else if (xfer)   back[fidx].sp.bitmap_lo <= vram_rdata;
                end
                S_FETCH_HI: begin
                    if (xfer) begin
                        back[fidx].sp.bitmap_hi <= vram_rdata;
                        fidx <= fidx + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/sp_eval_fetch.md
Name: sp_eval_fetch

Overview:
- Per-scanline sprite sequencer that builds the eight-entry secondary OAM consumed by the sprite pixel datapath.
- On command it scans the 64-entry primary OAM for sprites covering the target row, then fetches their pattern bytes over a shared VRAM read port.
- Results accumulate in a back buffer; a swap pulse at the line boundary copies them to the front buffer that drives the pixel logic.
- Sits between the PPU timing generator, the OAM RAM, the VRAM arbiter and the sprite pixel block.

Parameters:
- SPRITE_H, 8, sprite height in rows; 8x8 sprites only.
- N_SPRITES, 64, number of primary OAM entries.

Ports:
- clk  in  1  PPU clock.
- rst_n  in  1  asynchronous, active-low reset.
- eval_start  in  1  one-cycle pulse; begin evaluation for target_row.
- target_row  in  9  row being prepared; sampled on eval_start.
- swap  in  1  one-cycle pulse; commit back buffer to front.
- sp_table_sel  in  1  sprite pattern table select (PPUCTRL bit 3).
- oam_addr  out  8  primary OAM byte address.
- oam_rdata  in  8  OAM read data, valid the cycle after oam_addr.
- vram_req  out  1  pattern read request.
- vram_addr  out  14  pattern byte address.
- vram_ack  in  1  read done; vram_rdata valid this cycle.
- vram_rdata  in  8  pattern byte.
- sec_oam  out  second_oam_t[7:0]  front buffer.
- sp0_present  out  1  front slot 0 holds OAM sprite 0.
- sp_overflow  out  1  more than 8 sprites found for the front line.
- busy  out  1  state is not IDLE.

Behaviour:
- Reset: all outputs 0; both buffers all-inactive with zero fields; state IDLE.
- States and transitions:
  - IDLE --eval_start--> CLEAR.
  - CLEAR: 1 cycle; all back slots inactive, slot counter = 0, back overflow/sp0 flags = 0.
  - EVAL_Y --in range--> EVAL_T --> EVAL_A --> EVAL_X --> next sprite.
  - EVAL_Y --out of range--> next sprite.
  - EVAL ends after sprite 63 --> FETCH.
- OAM reads:
  - Each byte read takes 2 cycles: drive oam_addr = {n[5:0], byte[1:0]}, capture oam_rdata on the next cycle.
  - Miss costs 2 cycles; hit costs 8 cycles; worst-case EVAL is 176 cycles.
- Range test:
  - diff = target_row - {1'b0, y}, computed 9-bit unsigned.
  - In range iff diff < SPRITE_H. Negative differences wrap to large values and miss.
- Hits fill the next back slot: y diff, tile, attribute, x_pos, active = 1.
  - Sprite 0 hit: set back sp0 flag.
- Ninth hit: set back overflow, stop EVAL immediately, go to FETCH. The 9th sprite is not stored.
- FETCH: for each active slot in order 0..7, issue lo plane then hi plane read.
  - fine_y = attr[7] ? 7 - diff[2:0] : diff[2:0].
  - vram_addr = {1'b0, sp_table_sel, tile, plane, fine_y}.
  - vram_req is asserted, with vram_addr held stable, until vram_ack. Capture vram_rdata on the ack cycle; deassert the following cycle. Ack may arrive the same cycle as the request.
  - Inactive slots are skipped.
  - After the last active slot (or immediately if none) --> IDLE.
- swap while IDLE: front <= back, together with sp0_present and sp_overflow. The back buffer is unchanged.
- swap while busy: front <= all-inactive, sp0_present = 0, sp_overflow = 0. The evaluation continues.
- eval_start while busy: abort the current pass and enter CLEAR. An outstanding vram_req drops at once and any late ack is ignored.
- swap and eval_start in the same cycle while IDLE: the swap copies the old back buffer; then CLEAR.
- rst_n low at any time: immediate return to reset state.

Decomposition:
- Shared ppu package holds:
  - second_oam_t (existing): active, x_pos, attribute, bitmap_lo, bitmap_hi.
  - SPRITE_WIDTH, SPRITE_H, N_SPRITES, SEC_OAM_SLOTS = 8.
  - Eval state enum.
- Internal back-buffer entry extends second_oam_t with tile and row-diff fields.
- One combinational sub-module, sp_pat_addr, computes vram_addr from tile, diff, vflip, table_sel and plane.

Test Plan:
- Basic hit:
  - Stimulus: OAM0 = {y 10, tile 0x21, attr 0x00, x 50}, others y = 0xFF; target_row 12; sel 0; lo = 0xAA, hi = 0x55.
  - Response: vram_addr 0x0212 then 0x021A; after swap, slot 0 = {active, x 50, 0xAA/0x55}, sp0_present = 1, slots 1-7 inactive.
- Vertical flip:
  - Stimulus: same as basic hit with attr 0x80.
  - Response: addresses 0x0215 and 0x021D; attribute 0x80 stored.
- Overflow:
  - Stimulus: sprites 3..11 all y = 10, row 12.
  - Response: slots 0-7 hold sprites 3-10 in order; sp_overflow = 1; sp0_present = 0; sprite 11 not fetched.
- Range boundaries at row 12:
  - y = 5 hits.
  - y = 4 misses.
  - y = 12 hits.
  - y = 13 misses.
  - y = 200 misses (wrap).
- Handshake stall:
  - Stimulus: vram_ack delayed 3 cycles, then same-cycle ack.
  - Response: req/addr stable while waiting; exactly 2 reads per active slot.
- Abort and reset:
  - eval_start mid-FETCH: restart, no stale slot data.
  - swap while busy: front all-inactive, flags 0.
  - rst_n low mid-EVAL: all outputs 0.
